serial_tx_controller: RTL and testbench

Frame controller for the serial transmitter.
- After the sequence detector flags a start pattern, it shifts in a port address and a payload length from the serial line J.
- It then routes exactly that many payload bits from J onto the addressed output lane.
- It holds the sequence detector cleared while a frame is in progress, so payload bits cannot retrigger it.

---
 rtl/serial_tx_pkg.sv | 20 ++
 rtl/tx_bit_counter.sv | 31 +++
 rtl/serial_tx_controller.sv | 108 ++++++++++
 tb/tb_serial_tx_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// Shared types and defaults for the serial transmitter frame controller.
// Holds the frame FSM state encoding and the default field widths.
package serial_tx_pkg;

  localparam int PORT_W_DEF = 2;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    GET_PORT,
    GET_CNT,
    SEND,
    DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// Loadable down-counter shared by the header field bit count and the payload count.
// Saturates at zero and flags the terminal (count==1) and empty (count==0) conditions.
module tx_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc   = (count == W'(1));
  assign zero = (count == '0);

endmodule

// File: rtl/serial_tx_controller.sv
// Frame controller: after a detected start pattern, shifts in a port address and
// a payload length from J, then routes that many J bits onto the addressed lane.
module serial_tx_controller
  import serial_tx_pkg::*;
#(
  parameter int PORT_W = PORT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 J,
  input  logic                 Start,
  output logic                 DetClr,
  output logic [PORT_W-1:0]    Port,
  output logic [2**PORT_W-1:0] SerOut,
  output logic                 Valid,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CTR_W = max_int(PORT_W, CNT_W);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   len_shift;
  logic               ctr_load, ctr_dec, ctr_tc, ctr_zero;
  logic [CTR_W-1:0]   ctr_val;

  // Length as it will stand after this edge's bit is shifted in.
  assign len_shift = CNT_W'({len, J});

  tx_bit_counter #(.W(CTR_W)) u_ctr (
    .clk      (Clk),
    .rst_n    (Rst),
    .load     (ctr_load),
    .dec      (ctr_dec),
    .load_val (ctr_val),
    .tc       (ctr_tc),
    .zero     (ctr_zero)
  );

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_nxt = state;
    ctr_load  = 1'b0;
    ctr_dec   = 1'b0;
    ctr_val   = '0;
    SerOut    = '0;
    Valid     = 1'b0;
    Done      = 1'b0;
    Busy      = (state != IDLE);
    DetClr    = (state != IDLE);
    case (state)
      IDLE: begin
        if (Start) begin
          state_nxt = GET_PORT;
          ctr_load  = 1'b1;
          ctr_val   = CTR_W'(PORT_W - 1);
        end
      end
      GET_PORT: begin
        if (ctr_zero) begin
          state_nxt = GET_CNT;
          ctr_load  = 1'b1;
          ctr_val   = CTR_W'(CNT_W - 1);
        end else begin
          ctr_dec = 1'b1;
        end
      end
      GET_CNT: begin
        if (!ctr_zero) begin
          ctr_dec = 1'b1;
        end else if (len_shift != '0) begin
          state_nxt = SEND;
          ctr_load  = 1'b1;
          ctr_val   = CTR_W'(len_shift);
        end else begin
          state_nxt = DONE;
        end
      end
      SEND: begin
        Valid        = 1'b1;
        SerOut[Port] = J;
        ctr_dec      = 1'b1;
        if (ctr_tc) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: only control and field registers exist here, and all of them take the async reset.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      Port  <= '0;
      len   <= '0;
    end else begin
      state <= state_nxt;
      if (state == GET_PORT) Port <= PORT_W'({Port, J});
      if (state == GET_CNT)  len  <= len_shift;
    end
  end

endmodule

// File: tb/tb_serial_tx_controller.sv
// Self-checking bench for serial_tx_controller: each driven cycle pushes its
// expected outputs to a scoreboard that is compared on the following falling edge.
module tb_serial_tx_controller;

  logic       Clk, Rst, J, Start;
  logic       DetClr, Valid, Busy, Done;
  logic [1:0] Port;
  logic [3:0] SerOut;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic       busy;
    logic       valid;
    logic       done;
    logic [3:0] ser;
    logic [1:0] port;
    bit         chk_port;
  } exp_t;

  exp_t sb[$];
  logic [1:0] cur_port;

  serial_tx_controller #(.PORT_W(2), .CNT_W(4)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .J      (J),
    .Start  (Start),
    .DetClr (DetClr),
    .Port   (Port),
    .SerOut (SerOut),
    .Valid  (Valid),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input string tag, input logic busy, input logic valid,
                              input logic done, input logic [3:0] ser,
                              input logic [1:0] port, input bit chk_port);
    exp_t e;
    e.tag = tag; e.busy = busy; e.valid = valid; e.done = done;
    e.ser = ser; e.port = port; e.chk_port = chk_port;
    return e;
  endfunction

  // Outputs are compared mid-cycle, away from the rising edge.
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".busy"},   32'(Busy),   32'(e.busy));
      check({e.tag, ".detclr"}, 32'(DetClr), 32'(e.busy));
      check({e.tag, ".valid"},  32'(Valid),  32'(e.valid));
      check({e.tag, ".done"},   32'(Done),   32'(e.done));
      check({e.tag, ".serout"}, 32'(SerOut), 32'(e.ser));
      if (e.chk_port) check({e.tag, ".port"}, 32'(Port), 32'(e.port));
    end
  end

  task automatic step(input logic rst_v, input logic st_v, input logic j_v, input exp_t e);
    @(posedge Clk);
    #1;
    Rst   = rst_v;
    Start = st_v;
    J     = j_v;
    sb.push_back(e);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++)
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), mk("idle", 0, 0, 0, 4'h0, cur_port, 1));
  endtask

  // One full frame starting with the Start cycle; inj drives Start in non-IDLE states.
  task automatic frame(input string tag, input int p, input int n,
                       input logic [14:0] pay, input bit inj);
    logic [1:0] pb;
    logic [3:0] nb;
    logic [3:0] s;
    pb = 2'(p);
    nb = 4'(n);
    step(1'b1, 1'b1, 1'b0, mk({tag, ".start"}, 0, 0, 0, 4'h0, cur_port, 1));
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b0, pb[1-i], mk({tag, ".port_bit"}, 1, 0, 0, 4'h0, 2'b00, 0));
    for (int i = 0; i < 4; i++)
      step(1'b1, inj && (i == 2), nb[3-i], mk({tag, ".len_bit"}, 1, 0, 0, 4'h0, pb, (i > 0)));
    for (int i = 0; i < n; i++) begin
      s = '0;
      s[pb] = pay[i];
      step(1'b1, inj && (i == 0), pay[i], mk({tag, ".send"}, 1, 1, 0, s, pb, 1));
    end
    step(1'b1, inj, 1'($urandom_range(0, 1)), mk({tag, ".done"}, 1, 0, 1, 4'h0, pb, 1));
    cur_port = pb;
  endtask

  // Frame to port 1, length 5, reset pulled during the second payload bit.
  task automatic abort_frame();
    step(1'b1, 1'b1, 1'b0, mk("abort.start", 0, 0, 0, 4'h0, cur_port, 1));
    step(1'b1, 1'b0, 1'b0, mk("abort.port_bit", 1, 0, 0, 4'h0, 2'b00, 0));
    step(1'b1, 1'b0, 1'b1, mk("abort.port_bit", 1, 0, 0, 4'h0, 2'b00, 0));
    step(1'b1, 1'b0, 1'b0, mk("abort.len_bit", 1, 0, 0, 4'h0, 2'b00, 0));
    step(1'b1, 1'b0, 1'b1, mk("abort.len_bit", 1, 0, 0, 4'h0, 2'b01, 1));
    step(1'b1, 1'b0, 1'b0, mk("abort.len_bit", 1, 0, 0, 4'h0, 2'b01, 1));
    step(1'b1, 1'b0, 1'b1, mk("abort.len_bit", 1, 0, 0, 4'h0, 2'b01, 1));
    step(1'b1, 1'b0, 1'b1, mk("abort.send", 1, 1, 0, 4'b0010, 2'b01, 1));
    step(1'b0, 1'b1, 1'b1, mk("abort.in_rst", 0, 0, 0, 4'h0, 2'b00, 1));
    step(1'b0, 1'b0, 1'b1, mk("abort.in_rst", 0, 0, 0, 4'h0, 2'b00, 1));
    step(1'b1, 1'b0, 1'b1, mk("abort.release", 0, 0, 0, 4'h0, 2'b00, 1));
    cur_port = 2'b00;
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; J = 1'b0;
    cur_port = 2'b00;

    step(1'b0, 1'b1, 1'b1, mk("reset", 0, 0, 0, 4'h0, 2'b00, 1));
    step(1'b0, 1'b0, 1'b0, mk("reset", 0, 0, 0, 4'h0, 2'b00, 1));
    idle(2);

    frame("f_p2_n3", 2, 3, 15'b101, 1'b0);
    idle(2);
    frame("f_p1_n0", 1, 0, 15'b0, 1'b0);
    idle(1);
    frame("f_p3_n15", 3, 15, 15'b010101010101010, 1'b0);
    idle(1);
    frame("f_inject", 2, 2, 15'b11, 1'b1);
    idle(1);
    abort_frame();
    frame("f_after_rst", 0, 1, 15'b1, 1'b0);
    idle(1);
    frame("b2b_a", 1, 2, 15'b10, 1'b0);
    frame("b2b_b", 3, 1, 15'b1, 1'b0);
    idle(2);

    repeat (3) @(posedge Clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
